// File: rtl/mem_resp_pkg.sv
// Shared definitions for the miniSRC memory responder: FSM state codes,
// request op encoding, default wait-state count and an address range helper.
package mem_resp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WAIT    = 2'd1;
    localparam state_t ST_RESP    = 2'd2;
    localparam state_t ST_RELEASE = 2'd3;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int unsigned WAIT_CYCLES_DEFAULT = 2;

    function automatic logic in_range(input int unsigned word_addr, input int unsigned depth);
        return word_addr < depth;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port synchronous word array; addresses at or beyond DEPTH read as
// zero and ignore writes so a short array never aliases.
module sram_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 512,
    parameter string       INIT_FILE = ""
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              hit;

    assign idx = IDX_W'(addr);
    assign hit = in_range(32'(addr), DEPTH);

    always_ff @(posedge clock) begin
        if (we && hit) begin
            mem[idx] <= wdata;
        end
        rdata <= hit ? mem[idx] : '0;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the miniSRC MAR/MDR interface: latches one request,
// inserts WAIT_CYCLES wait states, accesses the array and pulses ready once.
//
// state   | meaning
// IDLE    | waiting for exactly one enable; latches addr/data/op
// WAIT    | wait states counting down; array access on the exit edge
// RESP    | ready (and error if out of range) high for this one cycle
// RELEASE | holding until both enables drop, so a held request is not re-serviced
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enable,
    input  logic              write_enable,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              busy,
    output logic              error
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    op_t               op_q;
    logic              oor_q;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_we;
    logic              access_now;

    // The array sees the live address in IDLE so a zero-wait read has its
    // word ready one edge after capture.
    assign ram_addr   = (state == ST_IDLE) ? addr : addr_q;
    assign access_now = (state == ST_WAIT) && (cnt == '0);
    assign ram_we     = access_now && (op_q == OP_WR) && !oor_q;

    sram_array #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            op_q     <= OP_RD;
            oor_q    <= 1'b0;
            data_out <= '0;
            ready    <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (read_enable ^ write_enable) begin
                        addr_q <= addr;
                        data_q <= data_in;
                        op_q   <= write_enable ? OP_WR : OP_RD;
                        oor_q  <= !in_range(32'(addr), DEPTH);
                        cnt    <= CNT_W'(WAIT_CYCLES);
                        busy   <= 1'b1;
                        state  <= ST_WAIT;
                    end else if (read_enable && write_enable) begin
                        error  <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ST_RELEASE;
                    end
                end
                ST_WAIT: begin
                    if (access_now) begin
                        ready <= 1'b1;
                        error <= oor_q;
                        if (op_q == OP_RD) begin
                            data_out <= oor_q ? '0 : ram_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!(read_enable || write_enable)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (2 waits/512 words, 0 waits/512
// words, 1 wait/256 words) checked against a word-array reference model.
module tb_mem_responder;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [NI];
    logic [8:0]  a     [NI];
    logic [31:0] din   [NI];
    logic        re    [NI];
    logic        we    [NI];
    logic [31:0] dout  [NI];
    logic        rdy   [NI];
    logic        bsy   [NI];
    logic        err   [NI];

    int unsigned waits [NI] = '{2, 0, 1};
    int unsigned depth [NI] = '{512, 512, 256};

    logic [31:0] mdl_mem   [NI][512];
    bit          mdl_valid [NI][512];
    logic [31:0] mdl_dout  [NI];

    int checks = 0;
    int errors = 0;

    mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(2), .INIT_FILE("")) u_w2 (
        .clock(clk), .reset(rst_n[0]), .addr(a[0]), .data_in(din[0]),
        .read_enable(re[0]), .write_enable(we[0]),
        .data_out(dout[0]), .ready(rdy[0]), .busy(bsy[0]), .error(err[0]));

    mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(0), .INIT_FILE("")) u_w0 (
        .clock(clk), .reset(rst_n[1]), .addr(a[1]), .data_in(din[1]),
        .read_enable(re[1]), .write_enable(we[1]),
        .data_out(dout[1]), .ready(rdy[1]), .busy(bsy[1]), .error(err[1]));

    mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(1), .INIT_FILE("")) u_d256 (
        .clock(clk), .reset(rst_n[2]), .addr(a[2]), .data_in(din[2]),
        .read_enable(re[2]), .write_enable(we[2]),
        .data_out(dout[2]), .ready(rdy[2]), .busy(bsy[2]), .error(err[2]));

    // Reference: an illegal request does nothing, out-of-range writes vanish,
    // out-of-range reads return zero, data_out tracks only completed reads.
    function automatic void model_apply(input int i, input bit rd, input bit wr,
                                        input logic [8:0] ad, input logic [31:0] d);
        bit oor = 32'(ad) >= depth[i];
        if (rd && wr) return;
        if (wr && !oor) begin
            mdl_mem[i][ad]   = d;
            mdl_valid[i][ad] = 1'b1;
        end
        if (rd) mdl_dout[i] = oor ? 32'h0 : mdl_mem[i][ad];
    endfunction

    // Drives one request from a negedge, observes it per cycle (sample n is the
    // negedge after capture edge + n - 1), holds the enable `hold` extra cycles
    // after completion, then drops it and watches for busy to fall.
    task automatic run_txn(input int i, input bit rd, input bit wr, input logic [8:0] ad,
                           input logic [31:0] d, input int hold,
                           output int rdy_at, output int rdy_cnt, output int err_at,
                           output int err_cnt, output bit busy_held, output int idle_at);
        int done_at = -1;
        rdy_at = -1; rdy_cnt = 0; err_at = -1; err_cnt = 0; busy_held = 1'b1; idle_at = -1;
        a[i] = ad; din[i] = d; re[i] = rd; we[i] = wr;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rdy[i] === 1'b1) begin rdy_cnt++; if (rdy_at < 0) rdy_at = n; end
            if (err[i] === 1'b1) begin err_cnt++; if (err_at < 0) err_at = n; end
            if (bsy[i] !== 1'b1) busy_held = 1'b0;
            if (done_at < 0 && (rdy_at > 0 || (rd && wr && err_at > 0))) done_at = n;
            if (done_at > 0 && n >= done_at + hold) break;
        end
        re[i] = 1'b0; we[i] = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (rdy[i] === 1'b1) rdy_cnt++;
            if (err[i] === 1'b1) err_cnt++;
            if (idle_at < 0 && bsy[i] === 1'b0) idle_at = n;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({dout[i], rdy[i], bsy[i], err[i]} !== 35'h0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d: data_out=%h ready=%b busy=%b error=%b, required all 0",
                         i, dout[i], rdy[i], bsy[i], err[i]);
            end
        end
    endtask

    task automatic test_write_read();
        int ra, rc, ea, ec, ia; bit bh;
        run_txn(0, 1'b0, 1'b1, 9'h005, 32'hDEAD_BEEF, 0, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b0, 1'b1, 9'h005, 32'hDEAD_BEEF);
        checks++;
        if (ra !== 4) begin errors++; $display("FAIL wr_latency: ready at sample %0d, required 4", ra); end
        checks++;
        if (rc !== 1 || ec !== 0) begin errors++; $display("FAIL wr_pulses: ready=%0d error=%0d, required 1/0", rc, ec); end
        checks++;
        if (ia !== 2) begin errors++; $display("FAIL wr_busy_drop: busy low at sample %0d, required 2", ia); end
        run_txn(0, 1'b1, 1'b0, 9'h005, 32'h0, 0, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b1, 1'b0, 9'h005, 32'h0);
        checks++;
        if (ra !== 4) begin errors++; $display("FAIL rd_latency: ready at sample %0d, required 4", ra); end
        checks++;
        if (dout[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: %h, required deadbeef", dout[0]); end
    endtask

    task automatic test_wait0();
        int ra, rc, ea, ec, ia; bit bh;
        run_txn(1, 1'b0, 1'b1, 9'h1FF, 32'h1234_5678, 0, ra, rc, ea, ec, bh, ia);
        model_apply(1, 1'b0, 1'b1, 9'h1FF, 32'h1234_5678);
        checks++;
        if (ra !== 2) begin errors++; $display("FAIL w0_wr_latency: ready at sample %0d, required 2", ra); end
        run_txn(1, 1'b1, 1'b0, 9'h1FF, 32'h0, 0, ra, rc, ea, ec, bh, ia);
        model_apply(1, 1'b1, 1'b0, 9'h1FF, 32'h0);
        checks++;
        if (ra !== 2) begin errors++; $display("FAIL w0_rd_latency: ready at sample %0d, required 2", ra); end
        checks++;
        if (dout[1] !== 32'h1234_5678) begin errors++; $display("FAIL w0_rd_data: %h, required 12345678", dout[1]); end
    endtask

    task automatic test_held();
        int ra, rc, ea, ec, ia; bit bh;
        run_txn(0, 1'b1, 1'b0, 9'h005, 32'h0, 10, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b1, 1'b0, 9'h005, 32'h0);
        checks++;
        if (rc !== 1) begin errors++; $display("FAIL held_ready_count: %0d pulses, required 1", rc); end
        checks++;
        if (bh !== 1'b1) begin errors++; $display("FAIL held_busy: busy dropped while enable held, required high"); end
        checks++;
        if (ia !== 1) begin errors++; $display("FAIL held_release: busy low at sample %0d, required 1", ia); end
    endtask

    task automatic test_illegal();
        int ra, rc, ea, ec, ia; bit bh;
        logic [31:0] v = $urandom;
        run_txn(0, 1'b0, 1'b1, 9'h010, v, 0, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b0, 1'b1, 9'h010, v);
        run_txn(0, 1'b1, 1'b0, 9'h005, 32'h0, 0, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b1, 1'b0, 9'h005, 32'h0);
        run_txn(0, 1'b1, 1'b1, 9'h010, ~v, 0, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b1, 1'b1, 9'h010, ~v);
        checks++;
        if (ea !== 1 || ec !== 1) begin errors++; $display("FAIL ill_error: first at %0d count %0d, required 1/1", ea, ec); end
        checks++;
        if (rc !== 0) begin errors++; $display("FAIL ill_ready: %0d pulses, required 0", rc); end
        checks++;
        if (dout[0] !== mdl_dout[0]) begin errors++; $display("FAIL ill_data_out: %h, required %h", dout[0], mdl_dout[0]); end
        run_txn(0, 1'b1, 1'b0, 9'h010, 32'h0, 0, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b1, 1'b0, 9'h010, 32'h0);
        checks++;
        if (dout[0] !== v) begin errors++; $display("FAIL ill_array_word: %h, required %h", dout[0], v); end
    endtask

    task automatic test_reset_mid_write();
        int ra, rc, ea, ec, ia; bit bh;
        run_txn(0, 1'b0, 1'b1, 9'h020, 32'h1111_2222, 0, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b0, 1'b1, 9'h020, 32'h1111_2222);
        run_txn(0, 1'b1, 1'b0, 9'h005, 32'h0, 0, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b1, 1'b0, 9'h005, 32'h0);
        a[0] = 9'h020; din[0] = 32'hAAAA_5555; we[0] = 1'b1;
        @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        checks++;
        if ({dout[0], rdy[0], bsy[0], err[0]} !== 35'h0) begin
            errors++;
            $display("FAIL rst_async: data_out=%h ready=%b busy=%b error=%b, required all 0",
                     dout[0], rdy[0], bsy[0], err[0]);
        end
        we[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({dout[0], rdy[0], bsy[0], err[0]} !== 35'h0) begin
            errors++;
            $display("FAIL rst_held: data_out=%h ready=%b busy=%b error=%b, required all 0",
                     dout[0], rdy[0], bsy[0], err[0]);
        end
        rst_n[0] = 1'b1;
        mdl_dout[0] = 32'h0;
        @(negedge clk);
        run_txn(0, 1'b1, 1'b0, 9'h020, 32'h0, 0, ra, rc, ea, ec, bh, ia);
        model_apply(0, 1'b1, 1'b0, 9'h020, 32'h0);
        checks++;
        if (dout[0] !== 32'h1111_2222) begin errors++; $display("FAIL rst_abort_write: %h, required 11112222", dout[0]); end
    endtask

    task automatic test_out_of_range();
        int ra, rc, ea, ec, ia; bit bh;
        run_txn(2, 1'b0, 1'b1, 9'h030, 32'hC0FF_EE01, 0, ra, rc, ea, ec, bh, ia);
        model_apply(2, 1'b0, 1'b1, 9'h030, 32'hC0FF_EE01);
        run_txn(2, 1'b1, 1'b0, 9'h030, 32'h0, 0, ra, rc, ea, ec, bh, ia);
        model_apply(2, 1'b1, 1'b0, 9'h030, 32'h0);
        run_txn(2, 1'b1, 1'b0, 9'h1F0, 32'h0, 0, ra, rc, ea, ec, bh, ia);
        model_apply(2, 1'b1, 1'b0, 9'h1F0, 32'h0);
        checks++;
        if (ra !== 3 || ea !== 3) begin errors++; $display("FAIL oor_pulse: ready at %0d error at %0d, required 3/3", ra, ea); end
        checks++;
        if (rc !== 1 || ec !== 1) begin errors++; $display("FAIL oor_counts: ready=%0d error=%0d, required 1/1", rc, ec); end
        checks++;
        if (dout[2] !== 32'h0) begin errors++; $display("FAIL oor_data: %h, required 0", dout[2]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < NI; i++) begin
            for (int t = 0; t < 12; t++) begin
                int ra, rc, ea, ec, ia; bit bh;
                int kind = int'($urandom_range(0, 5));
                logic [8:0] ad = (i == 2) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 63));
                logic [31:0] d = $urandom;
                int hold = int'($urandom_range(0, 3));
                bit rd = (kind >= 3);
                bit wr = (kind <= 2) || (kind == 5);
                bit oor = 32'(ad) >= depth[i];
                if (rd && !wr && !oor && !mdl_valid[i][ad]) begin rd = 1'b0; wr = 1'b1; end
                run_txn(i, rd, wr, ad, d, hold, ra, rc, ea, ec, bh, ia);
                model_apply(i, rd, wr, ad, d);
                checks++;
                if (rd && wr) begin
                    if (rc !== 0 || ec !== 1) begin
                        errors++;
                        $display("FAIL rnd_illegal inst=%0d: ready=%0d error=%0d, required 0/1", i, rc, ec);
                    end
                end else begin
                    if (ra !== int'(waits[i]) + 2 || rc !== 1 || ec !== int'(oor)) begin
                        errors++;
                        $display("FAIL rnd_handshake inst=%0d addr=%h: ready at %0d count %0d error %0d, required %0d/1/%0d",
                                 i, ad, ra, rc, ec, int'(waits[i]) + 2, int'(oor));
                    end
                end
                checks++;
                if (dout[i] !== mdl_dout[i]) begin
                    errors++;
                    $display("FAIL rnd_data inst=%0d addr=%h: %h, required %h", i, ad, dout[i], mdl_dout[i]);
                end
                checks++;
                if (ia !== ((hold == 0 && !(rd && wr)) ? 2 : 1)) begin
                    errors++;
                    $display("FAIL rnd_busy inst=%0d: busy low at %0d, required %0d",
                             i, ia, (hold == 0 && !(rd && wr)) ? 2 : 1);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_n[i] = 1'b0; a[i] = '0; din[i] = '0; re[i] = 1'b0; we[i] = 1'b0;
            mdl_dout[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        @(negedge clk);
        test_write_read();
        test_wait0();
        test_held();
        test_illegal();
        test_reset_mid_write();
        test_out_of_range();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
